// File: rtl/fetcher_if.sv
// Start, fetch and decode-report signals of the warp fetcher.
// The fetcher uses the slave modport; its environment uses master.
interface fetcher_if #(
  parameter int PcWidth   = 32,
  parameter int NumWarps  = 8,
  parameter int WarpWidth = 32
);
  localparam int WidWidth = NumWarps > 1 ? $clog2(NumWarps) : 1;

  logic                 start_valid_i;
  logic                 start_ready_o;
  logic [PcWidth-1:0]   start_pc_i;
  logic [WarpWidth-1:0] start_act_mask_i;
  logic [WidWidth-1:0]  start_warp_id_o;
  logic                 ic_ready_i;
  logic                 fetch_valid_o;
  logic [PcWidth-1:0]   fetch_pc_o;
  logic [WarpWidth-1:0] fetch_act_mask_o;
  logic [WidWidth-1:0]  fetch_warp_id_o;
  logic                 dec_decoded_i;
  logic                 dec_stop_warp_i;
  logic [WidWidth-1:0]  dec_decoded_warp_id_i;
  logic [PcWidth-1:0]   dec_decoded_next_pc_i;
  logic [NumWarps-1:0]  warp_active_o;
  logic                 idle_o;

  modport slave (
    input  start_valid_i, start_pc_i, start_act_mask_i, ic_ready_i,
           dec_decoded_i, dec_stop_warp_i, dec_decoded_warp_id_i, dec_decoded_next_pc_i,
    output start_ready_o, start_warp_id_o, fetch_valid_o, fetch_pc_o,
           fetch_act_mask_o, fetch_warp_id_o, warp_active_o, idle_o
  );

  modport master (
    output start_valid_i, start_pc_i, start_act_mask_i, ic_ready_i,
           dec_decoded_i, dec_stop_warp_i, dec_decoded_warp_id_i, dec_decoded_next_pc_i,
    input  start_ready_o, start_warp_id_o, fetch_valid_o, fetch_pc_o,
           fetch_act_mask_o, fetch_warp_id_o, warp_active_o, idle_o
  );
endinterface

// File: rtl/fetcher.sv
// Per-warp PC/mask holder with round-robin fetch issue; one instruction in
// flight per warp, released by the decoder's next-PC or stop report.
module fetcher_slot #(
  parameter int PcWidth   = 32,
  parameter int WarpWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_en_i,
  input  logic                 fetch_en_i,
  input  logic                 dec_en_i,
  input  logic                 dec_stop_i,
  input  logic [PcWidth-1:0]   start_pc_i,
  input  logic [WarpWidth-1:0] start_mask_i,
  input  logic [PcWidth-1:0]   next_pc_i,
  output logic                 ready_o,
  output logic                 waiting_o,
  output logic                 inactive_o,
  output logic [PcWidth-1:0]   pc_o,
  output logic [WarpWidth-1:0] mask_o
);
  typedef enum logic [1:0] {INACTIVE, READY, WAITING} state_e;

  state_e               state_q, state_d;
  logic [PcWidth-1:0]   pc_q, pc_d;
  logic [WarpWidth-1:0] mask_q, mask_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    case (state_q)
      INACTIVE: if (start_en_i) begin
        state_d = READY;
        pc_d    = start_pc_i;
        mask_d  = start_mask_i;
      end
      READY:    if (fetch_en_i) state_d = WAITING;
      // reports reaching a slot in any other state fall through untouched
      WAITING:  if (dec_en_i) begin
        state_d = dec_stop_i ? INACTIVE : READY;
        if (!dec_stop_i) pc_d = next_pc_i;
      end
      default:  state_d = INACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INACTIVE;
      pc_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
    end
  end

  assign ready_o    = (state_q == READY);
  assign waiting_o  = (state_q == WAITING);
  assign inactive_o = (state_q == INACTIVE);
  assign pc_o       = pc_q;
  assign mask_o     = mask_q;
endmodule

module fetcher #(
  parameter int PcWidth   = 32,
  parameter int NumWarps  = 8,
  parameter int WarpWidth = 32,
  parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
  input logic       clk_i,
  input logic       rst_ni,
  fetcher_if.slave  bus
);
  typedef logic [WidWidth-1:0] wid_t;

  logic [NumWarps-1:0]                slot_ready, slot_waiting, slot_inactive;
  logic [NumWarps-1:0][PcWidth-1:0]   slot_pc;
  logic [NumWarps-1:0][WarpWidth-1:0] slot_mask;

  logic lock_q;
  wid_t lock_id_q, rr_q;
  logic grant_found, free_found;
  wid_t grant_id, free_id, sel_id;
  logic fetch_valid, fetch_fire, start_fire;

  // first READY slot at or after rr, wrapping
  always_comb begin
    logic [WidWidth:0] sum;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = '0;
    for (int i = 0; i < NumWarps; i++) begin
      sum = {1'b0, rr_q} + (WidWidth+1)'(i);
      if (sum >= (WidWidth+1)'(NumWarps)) sum = sum - (WidWidth+1)'(NumWarps);
      if (!grant_found && slot_ready[wid_t'(sum)]) begin
        grant_found = 1'b1;
        grant_id    = wid_t'(sum);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NumWarps-1; i >= 0; i--) begin
      if (slot_inactive[i]) begin
        free_found = 1'b1;
        free_id    = wid_t'(i);
      end
    end
  end

  // a locked slot stays READY with frozen PC/mask, so holding its id suffices
  assign sel_id      = lock_q ? lock_id_q : grant_id;
  assign fetch_valid = lock_q | grant_found;
  assign fetch_fire  = fetch_valid & bus.ic_ready_i;
  assign start_fire  = bus.start_valid_i & free_found;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_q      <= '0;
    end else if (fetch_fire) begin
      lock_q <= 1'b0;
      rr_q   <= (sel_id == wid_t'(NumWarps-1)) ? '0 : sel_id + 1'b1;
    end else if (fetch_valid) begin
      lock_q    <= 1'b1;
      lock_id_q <= sel_id;
    end
  end

  for (genvar w = 0; w < NumWarps; w++) begin : g_slot
    fetcher_slot #(.PcWidth(PcWidth), .WarpWidth(WarpWidth)) u_slot (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_en_i   (start_fire && free_id == wid_t'(w)),
      .fetch_en_i   (fetch_fire && sel_id == wid_t'(w)),
      .dec_en_i     (bus.dec_decoded_i && bus.dec_decoded_warp_id_i == wid_t'(w)),
      .dec_stop_i   (bus.dec_stop_warp_i),
      .start_pc_i   (bus.start_pc_i),
      .start_mask_i (bus.start_act_mask_i),
      .next_pc_i    (bus.dec_decoded_next_pc_i),
      .ready_o      (slot_ready[w]),
      .waiting_o    (slot_waiting[w]),
      .inactive_o   (slot_inactive[w]),
      .pc_o         (slot_pc[w]),
      .mask_o       (slot_mask[w])
    );
  end

  assign bus.fetch_valid_o    = fetch_valid;
  assign bus.fetch_pc_o       = fetch_valid ? slot_pc[sel_id]   : '0;
  assign bus.fetch_act_mask_o = fetch_valid ? slot_mask[sel_id] : '0;
  assign bus.fetch_warp_id_o  = fetch_valid ? sel_id            : '0;
  assign bus.start_ready_o    = free_found;
  assign bus.start_warp_id_o  = free_id;
  assign bus.warp_active_o    = ~slot_inactive;
  assign bus.idle_o           = &slot_inactive;

  a_dec_waiting: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.dec_decoded_i |-> slot_waiting[bus.dec_decoded_warp_id_i])
    else $warning("fetcher: decode report for slot %0d which is not waiting",
                  bus.dec_decoded_warp_id_i);
endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: vector table for the basic start/fetch/decode
// flow, hand sequences for round-robin, grant lock, full slots and reset.
module tb_fetcher;
  localparam logic [31:0] M = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fetcher_if #(.PcWidth(32), .NumWarps(8), .WarpWidth(32)) bus ();

  fetcher #(.PcWidth(32), .NumWarps(8), .WarpWidth(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic sv; logic [31:0] spc; logic [31:0] smask; logic icr;
    logic dd; logic ds; logic [2:0] did; logic [31:0] dpc;
    logic efv; logic [31:0] epc; logic [31:0] emask; logic [2:0] eid;
    logic esr; logic [2:0] esid; logic [7:0] eact; logic eidle;
  } vec_t;

  vec_t vecs [6];

  task automatic drive(input logic sv, input logic [31:0] spc, input logic [31:0] smask,
                       input logic icr, input logic dd, input logic ds,
                       input logic [2:0] did, input logic [31:0] dpc);
    bus.start_valid_i         = sv;
    bus.start_pc_i            = spc;
    bus.start_act_mask_i      = smask;
    bus.ic_ready_i            = icr;
    bus.dec_decoded_i         = dd;
    bus.dec_stop_warp_i       = ds;
    bus.dec_decoded_warp_id_i = did;
    bus.dec_decoded_next_pc_i = dpc;
  endtask

  task automatic check_fetch(input string nm, input logic efv, input logic [31:0] epc,
                             input logic [31:0] emask, input logic [2:0] eid);
    n_chk++;
    if (bus.fetch_valid_o === efv && bus.fetch_pc_o === epc &&
        bus.fetch_act_mask_o === emask && bus.fetch_warp_id_o === eid)
      n_pass++;
    else
      $display("FAIL %s: got v=%0d pc=%h mask=%h id=%0d, want v=%0d pc=%h mask=%h id=%0d",
               nm, bus.fetch_valid_o, bus.fetch_pc_o, bus.fetch_act_mask_o,
               bus.fetch_warp_id_o, efv, epc, emask, eid);
  endtask

  task automatic check_status(input string nm, input logic esr, input logic [2:0] esid,
                              input logic [7:0] eact, input logic eidle);
    n_chk++;
    if (bus.start_ready_o === esr && bus.start_warp_id_o === esid &&
        bus.warp_active_o === eact && bus.idle_o === eidle)
      n_pass++;
    else
      $display("FAIL %s: got sr=%0d sid=%0d act=%h idle=%0d, want sr=%0d sid=%0d act=%h idle=%0d",
               nm, bus.start_ready_o, bus.start_warp_id_o, bus.warp_active_o, bus.idle_o,
               esr, esid, eact, eidle);
  endtask

  // drive one cycle's inputs at the falling edge and check the fetch side
  task automatic step(input string nm, input logic sv, input logic [31:0] spc,
                      input logic [31:0] smask, input logic icr, input logic dd,
                      input logic ds, input logic [2:0] did, input logic [31:0] dpc,
                      input logic efv, input logic [31:0] epc, input logic [31:0] emask,
                      input logic [2:0] eid);
    @(negedge clk);
    drive(sv, spc, smask, icr, dd, ds, did, dpc);
    #1;
    check_fetch(nm, efv, epc, emask, eid);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h10, M, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,
                1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 3'd0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,
                1'b1, 32'h10, M, 3'd0, 1'b1, 3'd1, 8'h01, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h11,
                1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 3'd1, 8'h01, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,
                1'b1, 32'h11, M, 3'd0, 1'b1, 3'd1, 8'h01, 1'b0};
    vecs[4] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 3'd0, 32'h99,
                1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 3'd1, 8'h01, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,
                1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 3'd0, 8'h00, 1'b1};

    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    check_fetch("in_reset_fetch", 1'b0, 32'h0, 32'h0, 3'd0);
    check_status("in_reset_status", 1'b1, 3'd0, 8'h00, 1'b1);
    do_reset();

    // basic start / fetch / decode / stop flow
    foreach (vecs[i]) begin
      step($sformatf("tbl%0d", i), vecs[i].sv, vecs[i].spc, vecs[i].smask, vecs[i].icr,
           vecs[i].dd, vecs[i].ds, vecs[i].did, vecs[i].dpc,
           vecs[i].efv, vecs[i].epc, vecs[i].emask, vecs[i].eid);
      check_status($sformatf("tbl%0d_st", i), vecs[i].esr, vecs[i].esid, vecs[i].eact, vecs[i].eidle);
    end

    // round-robin over 4 warps with the decoder answering the cycle after each fetch
    do_reset();
    for (int c = 0; c < 16; c++) begin
      logic [31:0] spc, smask, dpc, epc, emask;
      logic [2:0]  did, eid;
      int r, g;
      r = c - 2;
      g = c - 1;
      spc   = (c < 4) ? 32'(256 * (c + 1)) : 32'h0;
      smask = (c < 4) ? (32'hF << (4 * c)) : 32'h0;
      did   = (c >= 2) ? 3'(r % 4) : 3'd0;
      dpc   = (c >= 2) ? 32'(256 * (r % 4 + 1) + r / 4 + 1) : 32'h0;
      eid   = (c >= 1) ? 3'(g % 4) : 3'd0;
      epc   = (c >= 1) ? 32'(256 * (g % 4 + 1) + g / 4) : 32'h0;
      emask = (c >= 1) ? (32'hF << (4 * (g % 4))) : 32'h0;
      step($sformatf("rr%0d", c), c < 4, spc, smask, 1'b1, c >= 2, 1'b0, did, dpc,
           c >= 1, epc, emask, eid);
      check_status($sformatf("rr%0d_st", c), 1'b1, (c < 4) ? 3'(c) : 3'd4,
                   (c < 4) ? 8'((1 << c) - 1) : 8'h0F, c == 0);
    end

    // grant lock: slot 2 stalled while slot 0 (earlier in rr order) becomes ready
    do_reset();
    step("lk0", 1'b1, 32'hA0, 32'hF, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    step("lk1", 1'b1, 32'hB0, 32'hF0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'hA0, 32'hF, 3'd0);
    step("lk2", 1'b1, 32'hC0, 32'h00FF00FF, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'hB0, 32'hF0, 3'd1);
    step("lk3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'hC0, 32'h00FF00FF, 3'd2);
    step("lk4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd2, 32'hC4, 1'b0, 32'h0, 32'h0, 3'd0);
    step("lk5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'hA4, 1'b1, 32'hC4, 32'h00FF00FF, 3'd2);
    for (int k = 6; k < 10; k++)
      step($sformatf("lk%0d", k), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,
           1'b1, 32'hC4, 32'h00FF00FF, 3'd2);
    step("lk10", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'hC4, 32'h00FF00FF, 3'd2);
    step("lk11", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'hA4, 32'hF, 3'd0);

    // all slots full, start refused; stop on slot 5 frees it one cycle later
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step($sformatf("full%0d", c), 1'b1, 32'(32'h1000 + c), 32'(c + 1), 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,
           c > 0, (c > 0) ? 32'h1000 : 32'h0, (c > 0) ? 32'h1 : 32'h0, 3'd0);
      check_status($sformatf("full%0d_st", c), 1'b1, 3'(c), 8'((1 << c) - 1), c == 0);
    end
    for (int c = 8; c < 10; c++) begin
      step($sformatf("full%0d", c), 1'b1, 32'hDEAD, 32'hDEAD, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,
           1'b1, 32'h1000, 32'h1, 3'd0);
      check_status($sformatf("full%0d_st", c), 1'b0, 3'd0, 8'hFF, 1'b0);
    end
    for (int k = 0; k < 6; k++)
      step($sformatf("fullfetch%0d", k), 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0,
           1'b1, 32'(32'h1000 + k), 32'(k + 1), 3'(k));
    step("stop5", 1'b1, 32'hBEEF, 32'hBEEF, 1'b0, 1'b1, 1'b1, 3'd5, 32'h777,
         1'b1, 32'h1006, 32'h7, 3'd6);
    check_status("stop5_st", 1'b0, 3'd0, 8'hFF, 1'b0);
    step("freed5", 1'b1, 32'h5555, 32'h55, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,
         1'b1, 32'h1006, 32'h7, 3'd6);
    check_status("freed5_st", 1'b1, 3'd5, 8'hDF, 1'b0);
    step("restart5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,
         1'b1, 32'h1006, 32'h7, 3'd6);
    check_status("restart5_st", 1'b0, 3'd0, 8'hFF, 1'b0);
    step("g6", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h1006, 32'h7, 3'd6);
    step("g7", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h1007, 32'h8, 3'd7);
    step("g5", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h5555, 32'h55, 3'd5);

    // async reset with three warps in flight; a late report must be ignored
    do_reset();
    step("ar0", 1'b1, 32'h700, 32'h1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    step("ar1", 1'b1, 32'h710, 32'h2, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h700, 32'h1, 3'd0);
    step("ar2", 1'b1, 32'h720, 32'h4, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h710, 32'h2, 3'd1);
    step("ar3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h720, 32'h4, 3'd2);
    step("ar4", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    check_status("ar4_st", 1'b0 | 1'b1, 3'd3, 8'h07, 1'b0);
    rst_n = 1'b0;
    #1;
    check_fetch("ar_rst", 1'b0, 32'h0, 32'h0, 3'd0);
    check_status("ar_rst_st", 1'b1, 3'd0, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_dec", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h55, 1'b0, 32'h0, 32'h0, 3'd0);
    step("ar_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    check_status("ar_after_st", 1'b1, 3'd0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetcher.md
# fetcher

Per-warp program-counter and scheduling stage directly upstream of the instruction cache and decoder in the compute unit. The block holds the PC and active mask of every warp slot and starts warps on request. Each cycle it selects one fetchable warp round-robin and issues its PC to the instruction cache. It then blocks that warp until the decoder reports the next PC or a stop, so each warp has at most one instruction in flight.

## Interface
- PcWidth, 32, program counter width
- NumWarps, 8, warp slots per compute unit
- WarpWidth, 32, threads per warp (active mask width)
- WidWidth, NumWarps > 1 ? $clog2(NumWarps) : 1, dependent; do not override
- wid_t / pc_t / act_mask_t, logic vectors of WidWidth / PcWidth / WarpWidth; dependent
- Ports:
- clk_i  in  1  clock; all state on its rising edge (one clock domain)
- rst_ni  in  1  asynchronous, active-low reset
- start_valid_i  in  1  request to start a new warp
- start_ready_o  out  1  a free slot exists; handshake = start_valid_i && start_ready_o
- start_pc_i  in  PcWidth  first PC of new warp
- start_act_mask_i  in  WarpWidth  active mask of new warp
- start_warp_id_o  out  WidWidth  slot the next start will occupy (lowest-index INACTIVE slot)
- ic_ready_i  in  1  instruction cache accepts a fetch
- fetch_valid_o  out  1  fetch request valid
- fetch_pc_o  out  PcWidth  PC of selected warp
- fetch_act_mask_o  out  WarpWidth  active mask of selected warp
- fetch_warp_id_o  out  WidWidth  selected warp slot
- dec_decoded_i  in  1  decoder finished an instruction
- dec_stop_warp_i  in  1  that instruction terminates the warp
- dec_decoded_warp_id_i  in  WidWidth  warp the report refers to
- dec_decoded_next_pc_i  in  PcWidth  next PC of that warp
- warp_active_o  out  NumWarps  bit w set when slot w is not INACTIVE
- idle_o  out  1  all slots INACTIVE

## Operation
- Per-slot state: INACTIVE, READY, WAITING. Per-slot PC and active-mask registers.
- Start handshake: the slot at start_warp_id_o goes INACTIVE->READY. PC := start_pc_i; mask := start_act_mask_i.
- Fetch handshake (fetch_valid_o && ic_ready_i): the granted slot goes READY->WAITING. Its PC is not modified.
- Decode report, stop=0: slot dec_decoded_warp_id_i goes WAITING->READY with PC := dec_decoded_next_pc_i.
- Decode report, stop=1: the slot goes WAITING->INACTIVE. Its PC is left unchanged.
- A report naming a slot that is not WAITING is ignored. A simulation-only assertion fires on it.
- Arbitration: round-robin pointer rr. The grant is the first READY slot at index >= rr, wrapping modulo NumWarps. After a fetch handshake, rr := granted index + 1, wrapping NumWarps-1 -> 0.
- Grant lock: if fetch_valid_o=1 and ic_ready_i=0, the grant is registered and held. The held fetch_pc/mask/id must remain stable until the handshake, even if other slots become READY. The lock clears on handshake.
- fetch_valid_o = locked or any slot READY.
- When fetch_valid_o=0, fetch_pc_o, fetch_act_mask_o and fetch_warp_id_o are '0.
- start_ready_o = any slot INACTIVE. When none is INACTIVE, start_warp_id_o is '0.
- PC arithmetic is not done here; next PC is taken verbatim from the decoder.

## Timing
- Reset values:
  - all slots INACTIVE; PCs and masks '0; rr=0; lock cleared
  - fetch_valid_o=0, fetch_* outputs '0
  - start_ready_o=1, start_warp_id_o=0
  - warp_active_o='0, idle_o=1
- All outputs are combinational from registered state only. There is no combinational path from ic_ready_i, start_valid_i or dec_* to any output.
- Warp started in cycle t is visible as READY (fetch_valid_o may assert) in t+1.
- Decode report in cycle t makes the slot READY with the new PC in t+1. Minimum refetch spacing for one warp is therefore issue cycle + cache/decoder latency + 1.
- Simultaneous events in one cycle all apply: start to slot a, fetch of slot b, decode report for slot c.
  - A report for the slot being fetched cannot occur, since that slot is READY and not WAITING.
  - A stop report and a start in the same cycle: the freed slot is not offered to the start until t+1, because start_warp_id_o is computed from registered state.
- Asynchronous reset mid-operation returns every register to reset values immediately. In-flight fetches are forgotten, and later decode reports for them are ignored because all slots are INACTIVE.

## Test plan
- Reset, then start warp PC=0x10, mask=0xFFFFFFFF with ic_ready_i=1 -> next cycle fetch_valid_o=1, fetch_pc_o=0x10, id 0. The cycle after, fetch_valid_o=0 (slot 0 WAITING).
- Decode report id 0, next_pc=0x11, stop=0 -> next cycle fetch_pc_o=0x11. Then report stop=1 -> warp_active_o=0, idle_o=1, start_ready_o=1.
- Start 4 warps (ids 0-3), ic_ready_i=1, decoder reporting immediately with stop=0 -> grants strictly 0,1,2,3,0,… with no slot starved.
- Slot 2 granted with ic_ready_i=0 for 5 cycles while slot 0 becomes READY -> id 2, PC and mask held stable all 5 cycles. When ready rises, id 2 handshakes first, then id 0.
- Start 8 warps -> start_ready_o=0 with start_valid_i high and no state change. A stop on slot 5 -> next cycle start_ready_o=1, start_warp_id_o=5.
- Assert rst_ni low while 3 warps are WAITING, then send a decode report for id 1 -> all outputs at reset values, the report is ignored, and the assertion fires.
